// File: rtl/bsg_manycore_pod_row_reset_sequencer.sv
// bsg_manycore_pod_row_reset_sequencer: holds a pod row in reset, then releases enabled pods in ascending x with a fixed stagger
module bsg_manycore_pod_row_reset_sequencer #(
    parameter int num_pods_x_p     = 4,
    parameter int num_tiles_x_p    = 16,
    parameter int hold_cycles_p    = 16,
    parameter int stagger_cycles_p = 4
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic                                        start_v_i,
    input  logic [num_pods_x_p-1:0]                     start_mask_i,
    output logic                                        start_ready_o,
    output logic [num_pods_x_p-1:0][num_tiles_x_p-1:0]  reset_o,
    output logic [num_pods_x_p-1:0]                     pod_active_o,
    output logic                                        busy_o,
    output logic                                        done_o
);
    localparam int max_cycles_lp = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
    localparam int cnt_w_lp      = $clog2(max_cycles_lp + 1);
    localparam logic [cnt_w_lp-1:0] hold_init_lp    = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] stagger_init_lp = cnt_w_lp'(stagger_cycles_p - 1);

    typedef enum logic [1:0] {IDLE, HOLD, RELEASE, DONE} state_e;

    state_e                                       state_q, state_d;
    logic [cnt_w_lp-1:0]                          cnt_q, cnt_d;
    logic [num_pods_x_p-1:0]                      mask_q, mask_d, rel_q, rel_d, next_pod;
    logic [num_pods_x_p-1:0][num_tiles_x_p-1:0]   reset_q, reset_d;
    logic                                         ready_q, ready_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        next_pod = mask_q & (~mask_q + num_pods_x_p'(1));
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        rel_d    = rel_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start_v_i && ready_q) begin
                state_d = HOLD;
                cnt_d   = hold_init_lp;
                mask_d  = start_mask_i;
                rel_d   = '0;
            end
            HOLD, RELEASE: if (cnt_q != '0) begin
                cnt_d = cnt_q - cnt_w_lp'(1);
            end else if (mask_q != '0) begin
                // mask_q holds only the pods not yet released; its lowest set bit goes next
                rel_d   = rel_q | next_pod;
                mask_d  = mask_q & ~next_pod;
                cnt_d   = stagger_init_lp;
                state_d = RELEASE;
            end else begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        for (int x = 0; x < num_pods_x_p; x++)
            reset_d[x] = {num_tiles_x_p{~rel_d[x]}};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            rel_q   <= '0;
            reset_q <= '1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            rel_q   <= rel_d;
            reset_q <= reset_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign start_ready_o = ready_q;
    assign reset_o       = reset_q;
    assign pod_active_o  = rel_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_bsg_manycore_pod_row_reset_sequencer.sv
// tb_bsg_manycore_pod_row_reset_sequencer: vector table, random sequences and corner cases against a timing model
module tb_bsg_manycore_pod_row_reset_sequencer;
    localparam int NP = 3, NT = 4, HC = 4, SC = 2;

    logic                     clk_i = 1'b0;
    logic                     reset_n_i, start_v_i, start_ready_o, busy_o, done_o;
    logic [NP-1:0]            start_mask_i, pod_active_o;
    logic [NP-1:0][NT-1:0]    reset_o;

    logic                     start_v1, mask1, ready1, active1, busy1, done1;
    logic [0:0][1:0]          reset1;

    int checks = 0, failures = 0;
    logic [NP-1:0] exp_rel;

    typedef struct {
        logic [NP-1:0] mask;
        int            pulse_at;
        int            exp_done;
        logic [NP-1:0] exp_active;
    } vec_t;
    vec_t vt[5];

    bsg_manycore_pod_row_reset_sequencer #(
        .num_pods_x_p(NP), .num_tiles_x_p(NT), .hold_cycles_p(HC), .stagger_cycles_p(SC)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_v_i(start_v_i), .start_mask_i(start_mask_i),
        .start_ready_o(start_ready_o), .reset_o(reset_o), .pod_active_o(pod_active_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    bsg_manycore_pod_row_reset_sequencer #(
        .num_pods_x_p(1), .num_tiles_x_p(2), .hold_cycles_p(1), .stagger_cycles_p(3)
    ) dut1 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_v_i(start_v1), .start_mask_i(mask1),
        .start_ready_o(ready1), .reset_o(reset1), .pod_active_o(active1),
        .busy_o(busy1), .done_o(done1)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NP*NT-1:0] expand(input logic [NP-1:0] rel);
        logic [NP*NT-1:0] r;
        for (int x = 0; x < NP; x++) r[x*NT +: NT] = {NT{~rel[x]}};
        return r;
    endfunction

    // the k-th enabled pod (counting from 0 in ascending x) leaves reset at HC+1+k*SC after the handshake
    function automatic int rel_time(input logic [NP-1:0] m, input int x);
        int k = 0;
        for (int i = 0; i < x; i++) if (m[i]) k++;
        return HC + 1 + k * SC;
    endfunction

    function automatic int done_time(input logic [NP-1:0] m);
        return HC + 1 + $countones(m) * SC;
    endfunction

    task automatic check_outputs(input string tag, input logic [NP-1:0] rel, input bit busy, input bit done);
        chk({tag, " reset_o"}, 32'(reset_o), 32'(expand(rel)));
        chk({tag, " pod_active_o"}, 32'(pod_active_o), 32'(rel));
        chk({tag, " busy_o"}, 32'(busy_o), 32'(busy));
        chk({tag, " done_o"}, 32'(done_o), 32'(done));
        chk({tag, " start_ready_o"}, 32'(start_ready_o), 32'(!busy));
    endtask

    // entered just after a rising edge; that cycle is the handshake cycle (relative cycle 0)
    task automatic run_seq(input logic [NP-1:0] m, input int pulse_at, input int abort_at, output int seen_done);
        int d = done_time(m);
        int last = (abort_at > 0) ? abort_at : d + 1;
        seen_done = -1;
        start_v_i = 1'b1;
        start_mask_i = m;
        @(posedge clk_i); #1;
        start_v_i = 1'b0;
        start_mask_i = NP'($urandom);
        exp_rel = '0;
        for (int c = 1; c <= last; c++) begin
            for (int x = 0; x < NP; x++) if (m[x] && c >= rel_time(m, x)) exp_rel[x] = 1'b1;
            if (c == pulse_at) begin
                start_v_i = 1'b1;
                start_mask_i = NP'($urandom);
            end
            if (c == abort_at) reset_n_i = 1'b0;
            @(negedge clk_i);
            if (done_o === 1'b1 && seen_done < 0) seen_done = c;
            check_outputs($sformatf("seq m=%b c=%0d", m, c), exp_rel, c <= d, c == d);
            @(posedge clk_i); #1;
            start_v_i = 1'b0;
        end
        if (abort_at > 0) begin
            reset_n_i = 1'b1;
            exp_rel = '0;
            @(negedge clk_i);
            check_outputs("after mid-sequence reset", exp_rel, 1'b0, 1'b0);
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int sd;
        logic [NP-1:0] m;
        vt[0] = '{3'b101, 0, 9, 3'b101};
        vt[1] = '{3'b000, 0, 5, 3'b000};
        vt[2] = '{3'b111, 0, 11, 3'b111};
        vt[3] = '{3'b010, 0, 7, 3'b010};
        vt[4] = '{3'b111, 2, 11, 3'b111};
        reset_n_i = 1'b0;
        start_v_i = 1'b0;
        start_mask_i = '0;
        start_v1 = 1'b0;
        mask1 = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        exp_rel = '0;
        repeat (3) begin
            @(negedge clk_i);
            check_outputs("reset/idle", exp_rel, 1'b0, 1'b0);
            @(posedge clk_i); #1;
        end
        for (int i = 0; i < 5; i++) begin
            run_seq(vt[i].mask, vt[i].pulse_at, 0, sd);
            chk($sformatf("vec%0d done cycle", i), 32'(sd), 32'(vt[i].exp_done));
            chk($sformatf("vec%0d final active", i), 32'(pod_active_o), 32'(vt[i].exp_active));
        end
        run_seq(3'b111, 0, 6, sd);
        for (int i = 0; i < 20; i++) begin
            m = NP'($urandom);
            run_seq(m, $urandom_range(1, done_time(m)), 0, sd);
            chk($sformatf("rand%0d done cycle", i), 32'(sd), 32'(done_time(m)));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk_i);
                check_outputs("idle gap", exp_rel, 1'b0, 1'b0);
                @(posedge clk_i); #1;
            end
        end
        start_v1 = 1'b1;
        mask1 = 1'b1;
        @(posedge clk_i); #1;
        start_v1 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            chk($sformatf("one-pod reset c=%0d", c), 32'(reset1), (c >= 2) ? 32'h0 : 32'h3);
            chk($sformatf("one-pod active c=%0d", c), 32'(active1), 32'(c >= 2));
            chk($sformatf("one-pod done c=%0d", c), 32'(done1), 32'(c == 5));
            chk($sformatf("one-pod busy c=%0d", c), 32'(busy1), 32'(c <= 5));
            chk($sformatf("one-pod ready c=%0d", c), 32'(ready1), 32'(c > 5));
            @(posedge clk_i); #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
